// File: rtl/blake2b_compress_ctrl.sv
// BLAKE2b compression controller: walks the 8-step G schedule for ROUNDS rounds
// through an external G-mix unit with one clock of latency, then folds v into h.
module blake2b_compress_ctrl #(
  parameter int ROUNDS = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [511:0]  h_in,
  input  logic [1023:0] m_in,
  input  logic [127:0]  t_in,
  input  logic          last_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [511:0]  h_out,
  output logic [1023:0] mix_v,
  output logic [3:0]    mix_a,
  output logic [3:0]    mix_b,
  output logic [3:0]    mix_c,
  output logic [3:0]    mix_d,
  output logic [63:0]   mix_x,
  output logic [63:0]   mix_y,
  input  logic [1023:0] mix_v_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [511:0] IV = {
    64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
    64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
    64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
    64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
  };

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  logic [1:0]    state;
  logic [3:0]    r;
  logic [2:0]    j;
  logic [1023:0] v;
  logic [1023:0] m;
  logic [511:0]  h;
  logic [1023:0] vInit;
  logic [511:0]  hFinal;
  logic [3:0]    sigmaRow;
  logic [63:0]   sigmaBits;
  logic [3:0]    xIdx;
  logic [3:0]    yIdx;
  logic          lastStep;

  // Each SIGMA row is packed as 16 nibbles, entry k in bits [4k+:4].
  function automatic logic [63:0] sigmaLookup(input logic [3:0] row);
    logic [63:0] bits;
    bits = 64'hFEDCBA9876543210;
    case (row)
      4'd0: bits = 64'hFEDCBA9876543210;
      4'd1: bits = 64'h357B20C16DF984AE;
      4'd2: bits = 64'h491763EADF250C8B;
      4'd3: bits = 64'h8F04A562EBCD1397;
      4'd4: bits = 64'hD386CB1EFA427509;
      4'd5: bits = 64'h91EF57D438B0A6C2;
      4'd6: bits = 64'hB8293670A4DEF15C;
      4'd7: bits = 64'hA2684F05931CE7BD;
      4'd8: bits = 64'h5A417D2C803B9EF6;
      4'd9: bits = 64'h0DC3E9BF5167482A;
      default: bits = 64'hFEDCBA9876543210;
    endcase
    return bits;
  endfunction

  assign in_ready = (state == IDLE);
  assign mix_v    = v;
  assign lastStep = (r == LAST_ROUND) && (j == 3'd7);

  always_comb begin
    vInit = {IV, h_in};
    vInit[64*12 +: 64] = IV[64*4 +: 64] ^ t_in[63:0];
    vInit[64*13 +: 64] = IV[64*5 +: 64] ^ t_in[127:64];
    vInit[64*14 +: 64] = IV[64*6 +: 64] ^ {64{last_in}};
  end

  always_comb begin
    hFinal = '0;
    for (int i = 0; i < 8; i++) begin
      hFinal[64*i +: 64] = h[64*i +: 64] ^ mix_v_out[64*i +: 64] ^ mix_v_out[64*(i+8) +: 64];
    end
  end

  // Rounds 10 and 11 reuse SIGMA rows 0 and 1.
  always_comb begin
    sigmaRow  = (r >= 4'd10) ? (r - 4'd10) : r;
    sigmaBits = sigmaLookup(sigmaRow);
    xIdx      = sigmaBits[8*j +: 4];
    yIdx      = sigmaBits[8*j + 4 +: 4];
    mix_x     = m[64*xIdx +: 64];
    mix_y     = m[64*yIdx +: 64];
  end

  always_comb begin
    mix_a = 4'd0;
    mix_b = 4'd4;
    mix_c = 4'd8;
    mix_d = 4'd12;
    case (j)
      3'd0: begin mix_a = 4'd0; mix_b = 4'd4; mix_c = 4'd8;  mix_d = 4'd12; end
      3'd1: begin mix_a = 4'd1; mix_b = 4'd5; mix_c = 4'd9;  mix_d = 4'd13; end
      3'd2: begin mix_a = 4'd2; mix_b = 4'd6; mix_c = 4'd10; mix_d = 4'd14; end
      3'd3: begin mix_a = 4'd3; mix_b = 4'd7; mix_c = 4'd11; mix_d = 4'd15; end
      3'd4: begin mix_a = 4'd0; mix_b = 4'd5; mix_c = 4'd10; mix_d = 4'd15; end
      3'd5: begin mix_a = 4'd1; mix_b = 4'd6; mix_c = 4'd11; mix_d = 4'd12; end
      3'd6: begin mix_a = 4'd2; mix_b = 4'd7; mix_c = 4'd8;  mix_d = 4'd13; end
      3'd7: begin mix_a = 4'd3; mix_b = 4'd4; mix_c = 4'd9;  mix_d = 4'd14; end
      default: ;
    endcase
  end

  // ISSUE presents v to the mixer; WAIT takes its registered result one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= 4'd0;
      j         <= 3'd0;
      v         <= '0;
      m         <= '0;
      h         <= '0;
      h_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            h     <= h_in;
            m     <= m_in;
            v     <= vInit;
            r     <= 4'd0;
            j     <= 3'd0;
            state <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          v <= mix_v_out;
          if (j == 3'd7) begin
            j <= 3'd0;
            r <= r + 4'd1;
          end else begin
            j <= j + 3'd1;
          end
          if (lastStep) begin
            state     <= DONE;
            out_valid <= 1'b1;
            h_out     <= hFinal;
          end else begin
            state <= ISSUE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
